// File: rtl/mtr_step_gen_pkg.sv
// Shared types and constants for the film-transport stepper pulse generator.
package motor_pkg;

  localparam int POS_W = 32;
  localparam int SPD_W = 16;

  localparam int DEF_SETUP_CYC  = 16;
  localparam int DEF_PULSE_CYC  = 8;
  localparam int DEF_MIN_PERIOD = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/mtr_step_gen_if.sv
// Register-bank motor settings in, stepper driver signals and position out.
// No handshake: inputs are level settings sampled every bus_clk, pos_clr is a one-cycle pulse.
interface mtr_step_gen_if;
  import motor_pkg::*;

  logic             mtr_en;
  logic             mtr_dir;
  logic [SPD_W-1:0] mtr_speed;
  logic             pos_clr;
  logic             drv_step;
  logic             drv_dir;
  logic             drv_en_n;
  logic [POS_W-1:0] step_pos;
  logic             busy;
  state_e           state;

  modport master (
    output mtr_en, mtr_dir, mtr_speed, pos_clr,
    input  drv_step, drv_dir, drv_en_n, step_pos, busy, state
  );

  modport slave (
    input  mtr_en, mtr_dir, mtr_speed, pos_clr,
    output drv_step, drv_dir, drv_en_n, step_pos, busy, state
  );

endinterface

// File: rtl/mtr_step_gen.sv
// Converts static enable/direction/period settings into timed step/dir/enable
// driver signals while tracking a signed step position.
module mtr_step_gen
  import motor_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic          bus_clk,
  input  logic          rst,
  mtr_step_gen_if.slave bus
);

  localparam logic [SPD_W-1:0] SETUP_LAST = SPD_W'(SETUP_CYC - 1);
  localparam logic [SPD_W-1:0] PULSE_END  = SPD_W'(PULSE_CYC);
  localparam logic [SPD_W-1:0] MIN_P      = SPD_W'(MIN_PERIOD);

  state_e           state_q, state_d;
  logic [SPD_W-1:0] sc_q, sc_d;
  logic [SPD_W-1:0] pc_q, pc_d;
  logic [SPD_W-1:0] per_q, per_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             en_n_q, en_n_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             step_now;
  logic [SPD_W-1:0] per_eff;

  assign per_eff = (bus.mtr_speed < MIN_P) ? MIN_P : bus.mtr_speed;

  always_ff @(posedge bus_clk) begin
    if (rst) begin
      state_q <= IDLE;
      sc_q    <= '0;
      pc_q    <= '0;
      per_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      en_n_q  <= 1'b1;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      pc_q    <= pc_d;
      per_q   <= per_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      en_n_q  <= en_n_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    pc_d     = pc_q;
    per_d    = per_q;
    step_d   = step_q;
    dir_d    = dir_q;
    en_n_d   = en_n_q;
    pos_d    = pos_q;
    step_now = 1'b0;

    case (state_q)
      IDLE: begin
        en_n_d = 1'b1;
        step_d = 1'b0;
        if (bus.mtr_en) begin
          dir_d   = bus.mtr_dir;
          en_n_d  = 1'b0;
          sc_d    = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        step_d = 1'b0;
        sc_d   = sc_q + 1'b1;
        if (!bus.mtr_en) begin
          en_n_d  = 1'b1;
          sc_d    = '0;
          state_d = IDLE;
        end else if (sc_q == SETUP_LAST) begin
          sc_d    = '0;
          pc_d    = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (!bus.mtr_en && !step_q) begin
          en_n_d  = 1'b1;
          pc_d    = '0;
          state_d = IDLE;
        end else if (pc_q == '0) begin
          // Period boundary: a direction change replaces the step with a fresh setup interval.
          if (bus.mtr_dir != dir_q) begin
            dir_d   = bus.mtr_dir;
            sc_d    = '0;
            state_d = SETUP;
          end else if (bus.mtr_speed != '0) begin
            step_d   = 1'b1;
            step_now = 1'b1;
            per_d    = per_eff;
            pc_d     = 16'd1;
          end
        end else begin
          pc_d = (pc_q == per_q - 16'd1) ? '0 : pc_q + 16'd1;
          // Disable during a pulse is honoured only once the pulse has its full width.
          if (pc_q == PULSE_END) begin
            step_d = 1'b0;
            if (!bus.mtr_en) begin
              en_n_d  = 1'b1;
              pc_d    = '0;
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        en_n_d  = 1'b1;
        step_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (bus.pos_clr) begin
      pos_d = '0;
    end else if (step_now) begin
      pos_d = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
    end
  end

  assign bus.drv_step = step_q;
  assign bus.drv_dir  = dir_q;
  assign bus.drv_en_n = en_n_q;
  assign bus.step_pos = pos_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mtr_step_gen.sv
// Directed bench for mtr_step_gen: step latency, width, period, clamping,
// direction changes, disable handling, position wrap/clear and reset.
module tb_mtr_step_gen;
  import motor_pkg::*;

  logic bus_clk = 1'b0;
  logic rst     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   n;

  mtr_step_gen_if bus_if ();

  mtr_step_gen dut (
    .bus_clk (bus_clk),
    .rst     (rst),
    .bus     (bus_if)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(negedge bus_clk);
  endtask

  // Ticks until a drv_step rising transition; returns limit if none arrives.
  task automatic wait_rise(input int limit, output int cnt);
    logic prev;
    prev = bus_if.drv_step;
    cnt  = 0;
    while (cnt < limit) begin
      tick(1);
      cnt++;
      if (!prev && bus_if.drv_step) return;
      prev = bus_if.drv_step;
    end
  endtask

  task automatic wait_fall(input int limit, output int cnt);
    cnt = 0;
    while (cnt < limit && bus_if.drv_step) begin
      tick(1);
      cnt++;
    end
  endtask

  task automatic wait_dir(input logic val, input int limit, output int cnt);
    cnt = 0;
    while (cnt < limit && bus_if.drv_dir !== val) begin
      tick(1);
      cnt++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_step"},  32'(bus_if.drv_step), 32'd0);
    check({tag, "_dir"},   32'(bus_if.drv_dir),  32'd0);
    check({tag, "_en_n"},  32'(bus_if.drv_en_n), 32'd1);
    check({tag, "_pos"},   bus_if.step_pos,      32'd0);
    check({tag, "_busy"},  32'(bus_if.busy),     32'd0);
    check({tag, "_state"}, 32'(bus_if.state),    32'(IDLE));
  endtask

  initial begin
    int rises;
    bus_if.mtr_en    = 1'b0;
    bus_if.mtr_dir   = 1'b0;
    bus_if.mtr_speed = 16'd0;
    bus_if.pos_clr   = 1'b0;

    tick(3);
    check_reset_vals("rst0");
    rst = 1'b0;
    tick(2);
    check("idle_busy", 32'(bus_if.busy), 32'd0);

    // Forward run at period 100
    bus_if.mtr_en    = 1'b1;
    bus_if.mtr_dir   = 1'b1;
    bus_if.mtr_speed = 16'd100;
    tick(1);
    check("en_n_fall", 32'(bus_if.drv_en_n), 32'd0);
    check("dir_load",  32'(bus_if.drv_dir),  32'd1);
    check("busy_on",   32'(bus_if.busy),     32'd1);
    wait_rise(80, n);
    check("first_lat", 32'(n), 32'd17);
    check("pos1", bus_if.step_pos, 32'd1);
    wait_fall(40, n);
    check("width", 32'(n), 32'd8);
    wait_rise(200, n);
    check("period100_a", 32'(n + 8), 32'd100);
    check("pos2", bus_if.step_pos, 32'd2);
    wait_rise(200, n);
    check("period100_b", 32'(n), 32'd100);
    check("pos3", bus_if.step_pos, 32'd3);

    // Clamp: new speed only takes effect after the current period
    bus_if.mtr_speed = 16'd5;
    wait_rise(200, n);
    check("clamp_old_p", 32'(n), 32'd100);
    wait_rise(200, n);
    check("clamp_p", 32'(n), 32'd32);
    check("pos5", bus_if.step_pos, 32'd5);
    bus_if.mtr_speed = 16'd100;
    wait_rise(200, n);
    check("clamp_p2", 32'(n), 32'd32);
    check("pos6", bus_if.step_pos, 32'd6);

    // Direction change mid-period
    tick(10);
    bus_if.mtr_dir = 1'b0;
    wait_dir(1'b0, 200, n);
    check("dir_chg_at", 32'(n), 32'd90);
    check("dir_chg_nostep", 32'(bus_if.drv_step), 32'd0);
    check("dir_chg_state", 32'(bus_if.state), 32'(SETUP));
    wait_rise(80, n);
    check("dir_setup_lat", 32'(n), 32'd17);
    check("pos5_rev", bus_if.step_pos, 32'd5);
    wait_rise(200, n);
    check("rev_period", 32'(n), 32'd100);
    check("pos4_rev", bus_if.step_pos, 32'd4);

    // Disable two cycles into a pulse
    tick(1);
    bus_if.mtr_en = 1'b0;
    wait_fall(40, n);
    check("dis_pulse_w", 32'(n + 1), 32'd8);
    check("dis_en_n",  32'(bus_if.drv_en_n), 32'd1);
    check("dis_busy",  32'(bus_if.busy), 32'd0);
    check("dis_state", 32'(bus_if.state), 32'(IDLE));
    rises = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus_if.drv_step) rises++;
    end
    check("dis_nosteps", 32'(rises), 32'd0);

    // Disable at pc=50
    bus_if.mtr_en = 1'b1;
    tick(1);
    wait_rise(80, n);
    check("reen_lat", 32'(n), 32'd17);
    check("pos3_rev", bus_if.step_pos, 32'd3);
    tick(49);
    check("pc50_busy", 32'(bus_if.busy), 32'd1);
    bus_if.mtr_en = 1'b0;
    tick(1);
    check("pc50_busy_off", 32'(bus_if.busy), 32'd0);
    check("pc50_en_n", 32'(bus_if.drv_en_n), 32'd1);

    // Position clear and wrap below zero
    bus_if.pos_clr = 1'b1;
    tick(1);
    bus_if.pos_clr = 1'b0;
    check("clr_idle", bus_if.step_pos, 32'd0);
    bus_if.mtr_en = 1'b1;
    tick(1);
    wait_rise(80, n);
    check("wrap_lat", 32'(n), 32'd17);
    check("wrap_neg", bus_if.step_pos, 32'hFFFF_FFFF);
    tick(99);
    bus_if.pos_clr = 1'b1;
    tick(1);
    bus_if.pos_clr = 1'b0;
    check("clr_step_hi", 32'(bus_if.drv_step), 32'd1);
    check("clr_step_pos", bus_if.step_pos, 32'd0);

    // Reset during a pulse, then during SETUP
    tick(2);
    rst = 1'b1;
    tick(1);
    check_reset_vals("rst_pulse");
    bus_if.mtr_dir   = 1'b1;
    bus_if.mtr_speed = 16'd0;
    rst = 1'b0;
    tick(1);
    check("rst_rel_en_n", 32'(bus_if.drv_en_n), 32'd0);
    check("rst_rel_dir",  32'(bus_if.drv_dir), 32'd1);
    tick(5);
    check("setup_state", 32'(bus_if.state), 32'(SETUP));
    rst = 1'b1;
    tick(1);
    check_reset_vals("rst_setup");
    rst = 1'b0;

    // Hold at speed 0, then release with speed 40
    rises = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (bus_if.drv_step) rises++;
    end
    check("hold_nosteps", 32'(rises), 32'd0);
    check("hold_en_n", 32'(bus_if.drv_en_n), 32'd0);
    check("hold_state", 32'(bus_if.state), 32'(RUN));
    bus_if.mtr_speed = 16'd40;
    tick(1);
    check("resume_step", 32'(bus_if.drv_step), 32'd1);
    check("resume_pos", bus_if.step_pos, 32'd1);
    wait_rise(100, n);
    check("p40_a", 32'(n), 32'd40);
    wait_rise(100, n);
    check("p40_b", 32'(n), 32'd40);
    check("pos3_fwd", bus_if.step_pos, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
